// File: rtl/fir_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fir_pkg                                                                   |
// | Shared defaults, state encoding and accumulator width check for FIRs.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package fir_pkg;

    localparam int c_NTAPS     = 16;
    localparam int c_DW        = 16;
    localparam int c_ACCW      = 40;
    localparam int c_MULT_LAT  = 3;
    localparam int c_OUT_SHIFT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fir_state_e;

    // The accumulator must hold NTAPS full-scale products without wrapping.
    function automatic bit accw_is_legal(input int accw, input int dw, input int ntaps);
        return accw >= (2 * dw + $clog2(ntaps));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_sched_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fir_mac_sched_if                                                          |
// | Sample, coefficient, multiplier and output ports of the FIR scheduler.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface fir_mac_sched_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic                   s_valid;
    logic                   s_ready;
    logic signed [DW-1:0]   s_data;
    logic                   coef_we;
    logic [AW-1:0]          coef_addr;
    logic signed [DW-1:0]   coef_data;
    logic signed [DW-1:0]   mult_a;
    logic signed [DW-1:0]   mult_b;
    logic                   mult_ce;
    logic signed [2*DW-1:0] mult_dout;
    logic                   m_valid;
    logic                   m_ready;
    logic signed [DW-1:0]   m_data;
    logic                   busy;

    modport master (
        input  s_valid, s_data, coef_we, coef_addr, coef_data, mult_dout, m_ready,
        output s_ready, mult_a, mult_b, mult_ce, m_valid, m_data, busy
    );

    modport slave (
        output s_valid, s_data, coef_we, coef_addr, coef_data, mult_dout, m_ready,
        input  s_ready, mult_a, mult_b, mult_ce, m_valid, m_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/fir_round_sat.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fir_round_sat                                                             |
// | Round-half-up arithmetic right shift of an accumulator, then clamp to DW. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fir_round_sat #(
    parameter int ACCW      = 40,
    parameter int DW        = 16,
    parameter int OUT_SHIFT = 15
) (
    input  wire logic signed [ACCW-1:0] i_acc,
    output logic signed [DW-1:0]        o_data
);
    localparam logic signed [ACCW-1:0] c_HALF = ACCW'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACCW-1:0] c_MAX  = (ACCW'(1) << (DW - 1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] c_MIN  = ~c_MAX;

    logic signed [ACCW-1:0] w_rnd;
    logic signed [ACCW-1:0] w_shr;

    always_comb begin
        w_rnd = i_acc + c_HALF;
        w_shr = w_rnd >>> OUT_SHIFT;
        if (w_shr > c_MAX) begin
            o_data = c_MAX[DW-1:0];
        end else if (w_shr < c_MIN) begin
            o_data = c_MIN[DW-1:0];
        end else begin
            o_data = w_shr[DW-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/fir_mac_sched.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fir_mac_sched                                                             |
// | Time-multiplexed FIR: one shared multiplier, circular delay line, Q15 out.|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fir_mac_sched
    import fir_pkg::*;
#(
    parameter int NTAPS     = c_NTAPS,
    parameter int DW        = c_DW,
    parameter int ACCW      = c_ACCW,
    parameter int MULT_LAT  = c_MULT_LAT,
    parameter int OUT_SHIFT = c_OUT_SHIFT
) (
    input  wire logic        clk,
    input  wire logic        reset,
    fir_mac_sched_if.master  bus
);
    localparam int c_AW = $clog2(NTAPS);
    localparam int c_CW = $clog2(NTAPS + MULT_LAT);

    generate
        if (!accw_is_legal(ACCW, DW, NTAPS)) begin : g_accw_check
            $error("fir_mac_sched: ACCW too narrow for NTAPS full-scale products");
        end
    endgenerate

    fir_state_e             r_state;
    fir_state_e             w_state_nxt;
    logic [c_CW-1:0]        r_cnt;
    logic [c_AW-1:0]        r_wp;
    logic signed [DW-1:0]   r_x    [NTAPS];
    logic signed [DW-1:0]   r_coef [NTAPS];
    logic [MULT_LAT-1:0]    r_tag;
    logic signed [ACCW-1:0] r_acc;
    logic signed [ACCW-1:0] w_acc_nxt;
    logic signed [ACCW-1:0] w_prod;
    logic signed [DW-1:0]   r_m_data;
    logic signed [DW-1:0]   w_rs_out;

    logic            w_accept;
    logic            w_mac_done;
    logic            w_drain_done;
    logic            w_tag_out;
    logic [c_AW-1:0] w_tap;
    logic [c_AW-1:0] w_rd_idx;

    assign w_accept     = bus.s_valid && (r_state == IDLE);
    assign w_mac_done   = (r_state == MAC)   && (r_cnt == c_CW'(NTAPS - 1));
    assign w_drain_done = (r_state == DRAIN) && (r_cnt == c_CW'(MULT_LAT - 1));
    assign w_tap        = r_cnt[c_AW-1:0];
    // k = 0 reads the newest sample, older samples sit behind the write pointer.
    assign w_rd_idx     = r_wp - w_tap;
    assign w_tag_out    = r_tag[MULT_LAT-1];
    assign w_prod       = {{(ACCW - 2*DW){bus.mult_dout[2*DW-1]}}, bus.mult_dout};
    assign w_acc_nxt    = w_tag_out ? (r_acc + w_prod) : r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bus.s_ready = 1'b0;
        bus.busy    = 1'b1;
        bus.mult_ce = 1'b0;
        bus.m_valid = 1'b0;
        bus.mult_a  = '0;
        bus.mult_b  = '0;
        case (r_state)
            IDLE: begin
                bus.s_ready = 1'b1;
                bus.busy    = 1'b0;
                if (w_accept) w_state_nxt = MAC;
            end
            MAC: begin
                bus.mult_ce = 1'b1;
                bus.mult_a  = r_x[w_rd_idx];
                bus.mult_b  = r_coef[w_tap];
                if (w_mac_done) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.mult_ce = 1'b1;
                if (w_drain_done) w_state_nxt = OUT;
            end
            OUT: begin
                bus.m_valid = 1'b1;
                if (bus.m_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_wp  <= '0;
            r_tag <= '0;
            r_acc <= '0;
        end else begin
            if (w_accept || w_mac_done) begin
                r_cnt <= '0;
            end else if ((r_state == MAC) || (r_state == DRAIN)) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            if (w_mac_done) r_wp <= r_wp + c_AW'(1);
            // Each tag rides alongside its product through the multiplier pipe.
            r_tag <= MULT_LAT'({r_tag, (r_state == MAC)});
            r_acc <= w_accept ? '0 : w_acc_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_x[i]    <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            if (w_accept) r_x[r_wp] <= bus.s_data;
            if (bus.coef_we && (r_state == IDLE)) r_coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    fir_round_sat #(
        .ACCW      (ACCW),
        .DW        (DW),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .i_acc  (w_acc_nxt),
        .o_data (w_rs_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_data <= '0;
        end else if (w_drain_done) begin
            r_m_data <= w_rs_out;
        end
    end

    assign bus.m_data = r_m_data;
endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sched.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_fir_mac_sched                                                          |
// | Directed vectors against fir_mac_sched with a 3-stage multiplier model.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_fir_mac_sched;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    fir_mac_sched_if #(.DW(16), .AW(4)) bus ();

    fir_mac_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for fir_mult: A/B register, P register, O register, gated by ce.
    logic signed [15:0] r_ma, r_mb;
    logic signed [31:0] r_p, r_o;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ma <= '0; r_mb <= '0; r_p <= '0; r_o <= '0;
        end else if (bus.mult_ce) begin
            r_ma <= bus.mult_a;
            r_mb <= bus.mult_b;
            r_p  <= r_ma * r_mb;
            r_o  <= r_p;
        end
    end
    assign bus.mult_dout = r_o;

    task automatic do_reset();
        bus.s_valid = 1'b0; bus.s_data = '0; bus.coef_we = 1'b0;
        bus.coef_addr = '0; bus.coef_data = '0; bus.m_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic signed [15:0] d);
        bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
        @(posedge clk);
        #1 bus.coef_we = 1'b0;
    endtask

    task automatic write_all_coefs(input logic signed [15:0] d);
        for (int i = 0; i < 16; i++) write_coef(4'(i), d);
    endtask

    task automatic send(input logic signed [15:0] d, output bit to);
        int n = 0;
        bus.s_data = d; bus.s_valid = 1'b1; to = 1'b0;
        @(negedge clk);
        while (!bus.s_ready && n < 100) begin
            @(negedge clk); n++;
        end
        if (!bus.s_ready) to = 1'b1;
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic recv(output logic signed [15:0] d, output bit to);
        int n = 0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        while (!bus.m_valid && n < 100) begin
            @(negedge clk); n++;
        end
        to = !bus.m_valid;
        d  = bus.m_data;
        @(posedge clk);
        #1 bus.m_ready = 1'b0;
    endtask

    task automatic run_one(input string nm, input logic signed [15:0] din,
                           input logic signed [15:0] exp);
        logic signed [15:0] d;
        bit to1, to2;
        send(din, to1);
        recv(d, to2);
        n_vec++;
        if (to1 || to2 || d !== exp) begin
            n_err++;
            $display("FAIL %s: got %h (timeout %0b) want %h", nm, d, to1 | to2, exp);
        end
    endtask

    task automatic test_reset();
        int  cyc, ce_cnt;
        bit  to;
        logic signed [15:0] d;
        bus.s_valid = 1'b0; bus.coef_we = 1'b0; bus.m_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.s_ready, bus.m_valid, bus.mult_ce, bus.busy} !== 4'b1000 ||
            bus.m_data !== 16'sh0 || bus.mult_a !== 16'sh0 || bus.mult_b !== 16'sh0) begin
            n_err++;
            $display("FAIL reset_hold: rdy/val/ce/busy=%b data=%h a=%h b=%h want 1000/0/0/0",
                     {bus.s_ready, bus.m_valid, bus.mult_ce, bus.busy},
                     bus.m_data, bus.mult_a, bus.mult_b);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.s_ready, bus.m_valid, bus.mult_ce, bus.busy} !== 4'b1000 || bus.m_data !== 16'sh0) begin
            n_err++;
            $display("FAIL reset_release: rdy/val/ce/busy=%b data=%h want 1000/0000",
                     {bus.s_ready, bus.m_valid, bus.mult_ce, bus.busy}, bus.m_data);
        end
        @(posedge clk); #1;
        send(16'sh1234, to);
        cyc = 0;
        ce_cnt = bus.mult_ce ? 1 : 0;
        while (!bus.m_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mult_ce) ce_cnt++;
        end
        n_vec++;
        if (to || cyc != 19) begin
            n_err++;
            $display("FAIL latency: got %0d cycles want 19", cyc);
        end
        n_vec++;
        if (ce_cnt != 19) begin
            n_err++;
            $display("FAIL mult_ce_span: got %0d cycles want 19", ce_cnt);
        end
        recv(d, to);
        n_vec++;
        if (to || d !== 16'sh0) begin
            n_err++;
            $display("FAIL zero_coef_out: got %h want 0000", d);
        end
    endtask

    task automatic test_impulse();
        do_reset();
        write_all_coefs(16'sh4000);
        run_one("impulse[0]", 16'sh7FFF, 16'sh4000);
        for (int i = 1; i < 16; i++) run_one($sformatf("impulse[%0d]", i), 16'sh0, 16'sh4000);
        run_one("impulse[16]", 16'sh0, 16'sh0);
    endtask

    task automatic test_saturation();
        do_reset();
        write_all_coefs(16'sh7FFF);
        run_one("sat_pos[0]", 16'sh7FFF, 16'sh7FFE);
        for (int i = 1; i < 15; i++) run_one($sformatf("sat_pos[%0d]", i), 16'sh7FFF, 16'sh7FFF);
        run_one("sat_pos[15]", 16'sh7FFF, 16'sh7FFF);
        do_reset();
        write_all_coefs(16'sh7FFF);
        run_one("sat_neg[0]", -16'sh8000, 16'sh8001);
        for (int i = 1; i < 15; i++) run_one($sformatf("sat_neg[%0d]", i), -16'sh8000, -16'sh8000);
        run_one("sat_neg[15]", -16'sh8000, -16'sh8000);
    endtask

    task automatic test_backpressure();
        bit to;
        int n;
        logic signed [15:0] d;
        do_reset();
        write_all_coefs(16'sh4000);
        send(16'sh7FFF, to);
        n = 0;
        @(negedge clk);
        while (!bus.m_valid && n < 60) begin
            @(negedge clk); n++;
        end
        n_vec++;
        if (!bus.m_valid || bus.m_data !== 16'sh4000) begin
            n_err++;
            $display("FAIL bp_first: valid=%b data=%h want 1/4000", bus.m_valid, bus.m_data);
        end
        bus.s_valid = 1'b1; bus.s_data = 16'sh0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 16'sh4000 || bus.s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h s_ready=%b want 1/4000/0",
                         i, bus.m_valid, bus.m_data, bus.s_ready);
            end
        end
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
        @(posedge clk);
        #1 bus.m_ready = 1'b0;
        n_vec++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: s_ready=%b m_valid=%b want 1/0", bus.s_ready, bus.m_valid);
        end
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept: busy=%b want 1", bus.busy);
        end
        recv(d, to);
        n_vec++;
        if (to || d !== 16'sh4000) begin
            n_err++;
            $display("FAIL bp_second: got %h want 4000", d);
        end
    endtask

    task automatic test_coef_gating();
        bit to;
        logic signed [15:0] d;
        do_reset();
        write_all_coefs(16'sh4000);
        send(16'sh7FFF, to);
        repeat (2) @(posedge clk);
        #1;
        write_coef(4'd0, 16'sh0);
        recv(d, to);
        n_vec++;
        if (to || d !== 16'sh4000) begin
            n_err++;
            $display("FAIL gate_busy: got %h want 4000", d);
        end
        run_one("gate_kept", 16'sh7FFF, 16'sh7FFF);
        do_reset();
        bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 16'sh2000;
        bus.s_valid = 1'b1; bus.s_data = 16'sh7FFF;
        @(posedge clk);
        #1 begin bus.coef_we = 1'b0; bus.s_valid = 1'b0; end
        recv(d, to);
        n_vec++;
        if (to || d !== 16'sh2000) begin
            n_err++;
            $display("FAIL gate_same_edge: got %h want 2000", d);
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        do_reset();
        write_all_coefs(16'sh4000);
        run_one("midrst_pre", 16'sh7FFF, 16'sh4000);
        send(16'sh7FFF, to);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if ({bus.s_ready, bus.m_valid, bus.mult_ce, bus.busy} !== 4'b1000 ||
            bus.m_data !== 16'sh0 || bus.mult_a !== 16'sh0 || bus.mult_b !== 16'sh0) begin
            n_err++;
            $display("FAIL midrst_state: rdy/val/ce/busy=%b data=%h a=%h b=%h want 1000/0/0/0",
                     {bus.s_ready, bus.m_valid, bus.mult_ce, bus.busy},
                     bus.m_data, bus.mult_a, bus.mult_b);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        write_all_coefs(16'sh4000);
        run_one("midrst_clean0", 16'sh7FFF, 16'sh4000);
        run_one("midrst_clean1", 16'sh0, 16'sh4000);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        test_reset();
        test_impulse();
        test_saturation();
        test_backpressure();
        test_coef_gating();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fir_mac_sched.md
# fir_mac_sched

Time-multiplexed FIR controller that shares one `fir_mult` 16x16 signed multiplier across all taps. Accepts one input sample per valid/ready handshake, writes it into a circular delay line and issues one tap product per cycle to the multiplier. It tracks the multiplier's fixed pipeline latency, accumulates the returned products, then rounds and saturates the sum into one 16-bit output sample. It sits between the sample FIFO and the output FIFO, with `fir_mult` instantiated beside it at the same level.

## Interface
- NTAPS, 16, number of taps (power of two)
- DW, 16, sample and coefficient width (signed)
- ACCW, 40, accumulator width; must be ≥ 2*DW + log2(NTAPS)
- MULT_LAT, 3, multiplier latency in cycles (A/B reg, P reg, O reg)
- OUT_SHIFT, 15, right shift applied to the accumulator (Q15 coefficients)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_valid / s_ready  in / out  1 / 1  input sample handshake
- s_data  in  DW  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(NTAPS)  coefficient index
- coef_data  in  DW  signed coefficient
- mult_a / mult_b  out  DW / DW  multiplier operands (delay-line sample / coefficient)
- mult_ce  out  1  multiplier clock enable
- mult_dout  in  2*DW  multiplier product
- m_valid / m_ready  out / in  1 / 1  output sample handshake
- m_data  out  DW  signed filtered sample
- busy  out  1  high in every state except IDLE

## Operation
- State machine:
  - IDLE → MAC on s_valid & s_ready.
  - MAC lasts NTAPS cycles → DRAIN.
  - DRAIN lasts MULT_LAT cycles → OUT.
  - OUT → IDLE on m_ready.
- Port behaviour by state:
  - s_ready = (state == IDLE).
  - mult_ce = 1 in MAC and DRAIN, 0 otherwise.
- Delay line:
  - NTAPS x DW registers with write pointer wp.
  - On accept, x[wp] ← s_data; wp increments (mod NTAPS) on leaving MAC.
- Tap issue:
  - During MAC cycle k (k = 0..NTAPS-1): mult_a = x[(wp - k) mod NTAPS], mult_b = coef[k].
  - A 1-bit tag shift register of depth MULT_LAT marks issued products.
- Accumulation:
  - On the MAC entry edge, acc ← 0.
  - On each edge where the tag output is 1, acc ← acc + sign_ext(mult_dout).
- Output formation, on the DRAIN→OUT edge (this edge also performs the final accumulation):
  - r = (acc_final + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, arithmetic shift.
  - r is clamped to [-2^(DW-1), 2^(DW-1)-1] and registered into m_data.
- Coefficient writes:
  - Take effect only in IDLE and are silently dropped when busy.
  - A write and a sample accept on the same IDLE edge: the write lands, and the new sample uses the new coefficient.
- OUT: m_valid and m_data hold stable until m_ready; no new sample is accepted.
- Reset, including mid-operation:
  - State, wp, acc and tags clear immediately; delay line and coefficients clear to 0.
  - Stale products still in the multiplier's pipeline are ignored because their tags are cleared.
  - `fir_mult` reset is driven by the same reset net.
- Reset values: state=IDLE, s_ready=1, m_valid=0, m_data=0, mult_a=0, mult_b=0, mult_ce=0, busy=0.

## Timing
- Accept edge E0.
  - Tap k is driven in the cycle after E(k).
  - Its product is accumulated at edge E(k+1+MULT_LAT).
- m_valid rises after E(NTAPS+MULT_LAT), which is 19 cycles for default parameters.
- Minimum sample period: NTAPS+MULT_LAT+2 = 21 cycles (OUT ≥1 cycle, IDLE ≥1 cycle).
- The multiplier is never stalled mid-burst: mult_ce stays 1 for exactly NTAPS+MULT_LAT consecutive cycles.
- Accumulator overflow is impossible by the ACCW rule; only the output clamp saturates.

## Structure
- Shared package `fir_pkg` holds:
  - default NTAPS, DW, ACCW, MULT_LAT and OUT_SHIFT;
  - state encodings IDLE/MAC/DRAIN/OUT;
  - the ACCW legality check.
- One combinational sub-module, `fir_round_sat` (ACCW in → DW out, round-half-up then clamp), which is reused by other filter paths.
- Everything else, including the FSM, delay line and coefficient bank, stays in `fir_mac_sched`.

## Test plan
- Reset: hold reset, then release → s_ready=1, m_valid=0, m_data=0, mult_ce=0, busy=0. First accept after release gives m_valid exactly 19 cycles later.
- Impulse: all coef=0x4000; input 0x7FFF followed by 16 zeros → 16 outputs of 0x4000, then 0x0000.
- Saturation: all coef=0x7FFF; 16 samples of 0x7FFF → 16th output 0x7FFF. Repeat with 0x8000 inputs → 0x8000.
- Backpressure: m_ready low for 10 cycles in OUT → m_data/m_valid stable, s_ready=0, pending s_valid not accepted. Accepted 2 cycles after m_ready rises.
- Coefficient gating: write coef[0]=0 during MAC → result unchanged. Write coef[0]=0x2000 together with accept of 0x7FFF in IDLE (other coefs 0) → output 0x2000.
- Mid-operation reset: assert reset 5 cycles after accept → all outputs at reset values. Next impulse with coef 0x4000 → clean 0x4000 response with no residual product.
